// File: rtl/washer_motor_drv.sv
// washer_motor_drv
// ----------------
// Motor drive stage that sits after the washer controller and protects the
// motor and its H-bridge. It turns the controller's forward/reverse requests
// into two PWM gate signals that are never high together. It also adds:
//   - a soft-start duty ramp,
//   - a dead-time gap on every stop or reversal,
//   - a fault lock-out when both directions are requested at once.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   rst        in   asynchronous active-low reset
//   zheng      in   forward-rotation request (level)
//   fan        in   reverse-rotation request (level)
//   emergency  in   emergency stop (level, highest priority)
//   mot_fwd    out  forward bridge gate (PWM)
//   mot_rev    out  reverse bridge gate (PWM)
//   running    out  high while at full duty (RUN)
//   fault      out  high while locked out (FAULT)
//   duty       out  current duty value
//   st         out  state code: IDLE=0 RAMP=1 RUN=2 DEAD=3 FAULT=4
module washer_motor_drv #(
    parameter int PWM_W     = 4,
    parameter int RAMP_DIV  = 2,
    parameter int RAMP_INC  = 4,
    parameter int DEAD_TIME = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             zheng,
    input  logic             fan,
    input  logic             emergency,
    output logic             mot_fwd,
    output logic             mot_rev,
    output logic             running,
    output logic             fault,
    output logic [PWM_W-1:0] duty,
    output logic [2:0]       st
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        RUN   = 3'd2,
        DEAD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEAD_W = $clog2(DEAD_TIME + 1);

    localparam logic [PWM_W-1:0]  DMAX      = {PWM_W{1'b1}};
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_TIME);
    localparam logic [PWM_W:0]    INC       = (PWM_W + 1)'(RAMP_INC);

    state_t             state_q, state_d;
    logic [PWM_W-1:0]   duty_q, duty_d;
    logic [PWM_W-1:0]   cnt_q;
    logic               dir_q, dir_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DEAD_W-1:0]  dead_q, dead_d;

    logic [PWM_W:0]     rampSum;
    logic [PWM_W-1:0]   rampNext;
    logic               stopReq;
    logic               pwm;
    logic               driving;

    // State register plus the free-running PWM counter. Reset clears
    // everything at once, so the gates drop without a dead-time gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            div_q   <= '0;
            dead_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            cnt_q   <= cnt_q + PWM_W'(1);
            dir_q   <= dir_d;
            div_q   <= div_d;
            dead_q  <= dead_d;
        end
    end

    // The ramp sum is one bit wider than the duty so that overflow shows up
    // as a value above DMAX and can be clamped instead of wrapping.
    assign rampSum  = {1'b0, duty_q} + INC;
    assign rampNext = (rampSum > {1'b0, DMAX}) ? DMAX : rampSum[PWM_W-1:0];

    // Leave RAMP/RUN when the latched direction's request drops or the
    // opposite direction starts asking.
    assign stopReq  = dir_q ? (!fan || zheng) : (!zheng || fan);

    // Next-state logic. Emergency beats the both-high fault, and both of
    // them beat the per-state rules. A ramp step that coincides with a stop
    // is discarded, because the stop branch overrides the duty update.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        div_d   = div_q;
        dead_d  = dead_q;
        if (emergency) begin
            duty_d = '0;
            if (state_q != FAULT) begin
                state_d = DEAD;
                dead_d  = DEAD_LOAD;
            end
        end else if (zheng && fan) begin
            state_d = FAULT;
            duty_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    duty_d = '0;
                    if (zheng ^ fan) begin
                        dir_d   = fan;
                        state_d = RAMP;
                        div_d   = '0;
                    end
                end
                RAMP: begin
                    if (stopReq) begin
                        state_d = DEAD;
                        duty_d  = '0;
                        dead_d  = DEAD_LOAD;
                    end else if (div_q == DIV_LAST) begin
                        div_d  = '0;
                        duty_d = rampNext;
                        if (rampNext == DMAX) begin
                            state_d = RUN;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                RUN: begin
                    duty_d = DMAX;
                    if (stopReq) begin
                        state_d = DEAD;
                        duty_d  = '0;
                        dead_d  = DEAD_LOAD;
                    end
                end
                DEAD: begin
                    // The counter is loaded with DEAD_TIME on entry, so
                    // leaving on the edge where it reads 1 gives exactly
                    // DEAD_TIME cycles in DEAD.
                    duty_d = '0;
                    if (dead_q <= DEAD_W'(1)) begin
                        state_d = IDLE;
                        dead_d  = '0;
                    end else begin
                        dead_d = dead_q - DEAD_W'(1);
                    end
                end
                FAULT: begin
                    duty_d = '0;
                    state_d = DEAD;
                    dead_d  = DEAD_LOAD;
                end
                default: begin
                    state_d = IDLE;
                    duty_d  = '0;
                end
            endcase
        end
    end

    // Output decode. These outputs come from registers only, so an input
    // change cannot glitch a gate. Full duty forces the gate high for the
    // whole period. Without that, the counter reaching DMAX would cut one
    // cycle low in every period.
    always_comb begin
        pwm     = (duty_q == DMAX) || (cnt_q < duty_q);
        driving = (state_q == RAMP) || (state_q == RUN);
        mot_fwd = pwm && driving && !dir_q;
        mot_rev = pwm && driving && dir_q;
        running = (state_q == RUN);
        fault   = (state_q == FAULT);
        duty    = duty_q;
        st      = state_q;
    end

endmodule

// File: tb/tb_washer_motor_drv.sv
// tb_washer_motor_drv
// -------------------
// Directed bench for washer_motor_drv. It drives one default instance and
// one instance with PWM_W=3, RAMP_INC=5, and checks every observation with
// an immediate assertion.
module tb_washer_motor_drv;

    logic       clk = 1'b0;
    logic       rst;
    logic       zheng, fan, emergency;
    logic       mot_fwd, mot_rev, running, fault;
    logic [3:0] duty;
    logic [2:0] st;

    logic       zheng6, fan6, emerg6;
    logic       mot_fwd6, mot_rev6, running6, fault6;
    logic [2:0] duty6;
    logic [2:0] st6;

    int compared   = 0;
    int mismatched = 0;

    // Expected duty after each of the eight edges that follow RAMP entry
    int rampExp[8] = '{0, 4, 4, 8, 8, 12, 12, 15};

    logic [3:0] mCnt;

    washer_motor_drv dut (
        .clk(clk), .rst(rst), .zheng(zheng), .fan(fan), .emergency(emergency),
        .mot_fwd(mot_fwd), .mot_rev(mot_rev), .running(running), .fault(fault),
        .duty(duty), .st(st)
    );

    washer_motor_drv #(.PWM_W(3), .RAMP_INC(5)) dut6 (
        .clk(clk), .rst(rst), .zheng(zheng6), .fan(fan6), .emergency(emerg6),
        .mot_fwd(mot_fwd6), .mot_rev(mot_rev6), .running(running6), .fault(fault6),
        .duty(duty6), .st(st6)
    );

    always #5 clk = ~clk;

    // Reference PWM counter: counts rising edges since the last reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) mCnt <= 4'd0;
        else      mCnt <= mCnt + 4'd1;
    end

    function automatic int expPwm(input int d);
        return ((d == 15) || (int'(mCnt) < d)) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic z, input logic f, input logic e);
        zheng     = z;
        fan       = f;
        emergency = e;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(0, 0, 0);
        zheng6 = 0; fan6 = 0; emerg6 = 0;
        tick();
        tick();
        checkOutput("rst_st", st, 0);
        checkOutput("rst_duty", duty, 0);
        checkOutput("rst_fwd", mot_fwd, 0);
        checkOutput("rst_rev", mot_rev, 0);
        checkOutput("rst_running", running, 0);
        checkOutput("rst_fault", fault, 0);
        rst = 1'b1;
        tick();
        checkOutput("idle_hold", st, 0);

        // Forward ramp: duty steps every two edges, then RUN with the gate held high
        $display("[TB] forward soft start");
        applyStimulus(1, 0, 0);
        tick();
        checkOutput("fwd_enter_ramp", st, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput($sformatf("fwd_duty%0d", k), duty, rampExp[k]);
            checkOutput($sformatf("fwd_gate%0d", k), mot_fwd, expPwm(rampExp[k]));
            checkOutput($sformatf("fwd_rev%0d", k), mot_rev, 0);
        end
        checkOutput("fwd_run_st", st, 2);
        checkOutput("fwd_running", running, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("fwd_full%0d", k), mot_fwd, 1);
        end

        // Reversal on a single edge: dead time, IDLE, then reverse ramp
        $display("[TB] reversal");
        applyStimulus(0, 1, 0);
        tick();
        checkOutput("rev_dead_st", st, 3);
        checkOutput("rev_dead_fwd", mot_fwd, 0);
        checkOutput("rev_dead_duty", duty, 0);
        checkOutput("rev_dead_running", running, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("rev_dead%0d", k), st, 3);
        end
        tick();
        checkOutput("rev_idle", st, 0);
        tick();
        checkOutput("rev_ramp", st, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput($sformatf("rev_duty%0d", k), duty, rampExp[k]);
            checkOutput($sformatf("rev_gate%0d", k), mot_rev, expPwm(rampExp[k]));
            checkOutput($sformatf("rev_fwd%0d", k), mot_fwd, 0);
        end
        checkOutput("rev_run", st, 2);
        checkOutput("rev_full", mot_rev, 1);

        // Stop, then both requests during RAMP force FAULT
        $display("[TB] fault lock-out");
        applyStimulus(0, 0, 0);
        tick();
        checkOutput("stop_dead", st, 3);
        for (int k = 0; k < 3; k++) tick();
        tick();
        checkOutput("stop_idle", st, 0);
        applyStimulus(1, 0, 0);
        tick();
        checkOutput("flt_ramp", st, 1);
        tick();
        applyStimulus(1, 1, 0);
        tick();
        checkOutput("flt_st", st, 4);
        checkOutput("flt_fault", fault, 1);
        checkOutput("flt_fwd", mot_fwd, 0);
        checkOutput("flt_rev", mot_rev, 0);
        checkOutput("flt_duty", duty, 0);
        tick();
        checkOutput("flt_hold", st, 4);
        applyStimulus(0, 0, 0);
        tick();
        checkOutput("flt_release_st", st, 3);
        checkOutput("flt_release_fault", fault, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("flt_dead%0d", k), st, 3);
        end
        tick();
        checkOutput("flt_idle", st, 0);

        // Emergency held ten cycles in RUN keeps reloading the dead counter
        $display("[TB] emergency in RUN");
        applyStimulus(1, 0, 0);
        for (int k = 0; k < 9; k++) tick();
        checkOutput("em_run", running, 1);
        applyStimulus(1, 0, 1);
        tick();
        checkOutput("em_st", st, 3);
        checkOutput("em_fwd", mot_fwd, 0);
        checkOutput("em_running", running, 0);
        for (int k = 0; k < 9; k++) begin
            tick();
            checkOutput($sformatf("em_hold%0d", k), st, 3);
        end
        applyStimulus(0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("em_tail%0d", k), st, 3);
        end
        tick();
        checkOutput("em_idle", st, 0);

        // Emergency while in FAULT keeps FAULT
        $display("[TB] emergency in FAULT");
        applyStimulus(1, 1, 0);
        tick();
        checkOutput("emf_fault", st, 4);
        applyStimulus(0, 0, 1);
        tick();
        checkOutput("emf_stay", st, 4);
        applyStimulus(0, 0, 0);
        tick();
        checkOutput("emf_dead", st, 3);
        for (int k = 0; k < 3; k++) tick();
        tick();
        checkOutput("emf_idle", st, 0);

        // Asynchronous reset mid-ramp clears outputs immediately
        $display("[TB] async reset");
        applyStimulus(0, 1, 0);
        tick();
        checkOutput("ar_ramp", st, 1);
        tick();
        tick();
        checkOutput("ar_duty4", duty, 4);
        #2 rst = 1'b0;
        #1;
        checkOutput("ar_st", st, 0);
        checkOutput("ar_duty", duty, 0);
        checkOutput("ar_rev", mot_rev, 0);
        checkOutput("ar_fwd", mot_fwd, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        checkOutput("ar_restart", st, 1);
        checkOutput("ar_restart_duty", duty, 0);
        tick();
        tick();
        checkOutput("ar_step", duty, 4);
        checkOutput("ar_gate", mot_rev, expPwm(4));
        checkOutput("ar_nofwd", mot_fwd, 0);

        // Stop on the same edge as a ramp step: DEAD wins, the step is discarded
        tick();
        applyStimulus(0, 0, 0);
        tick();
        checkOutput("sim_st", st, 3);
        checkOutput("sim_duty", duty, 0);

        // Narrow instance: 0 -> 5 -> 7 (saturated), RUN after two steps
        $display("[TB] PWM_W=3 RAMP_INC=5");
        zheng6 = 1;
        tick();
        checkOutput("p6_ramp", st6, 1);
        tick();
        checkOutput("p6_d0", duty6, 0);
        tick();
        checkOutput("p6_d5", duty6, 5);
        checkOutput("p6_not_run", running6, 0);
        tick();
        checkOutput("p6_d5b", duty6, 5);
        tick();
        checkOutput("p6_d7", duty6, 7);
        checkOutput("p6_run", st6, 2);
        checkOutput("p6_gate", mot_fwd6, 1);
        checkOutput("p6_rev", mot_rev6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
